reg_wb_queue: RTL

//  Writeback queue for one register-file write port (e.g. the fpu_a port).

---
 rtl/reg_wb_queue.sv | 97 +++++++++
 1 files changed

// File: rtl/reg_wb_queue.sv
// Writeback queue for one register-file write port: buffers execution results,
// drains them in order into reg_file, and offers a forwarding lookup over pending writes.
module reg_wb_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     hold,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  input  logic [ADDR_W-1:0]        query_addr,
  output logic                     query_hit,
  output logic [DATA_W-1:0]        query_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             ent_q [DEPTH];
  logic [DEPTH-1:0]   vld_q, vld_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full, empty, push, pop;
  logic [PTR_W-1:0]   idx;

  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    empty    = (count_q == '0);
    in_ready = !full && !reset;
    wr_en    = !empty && !hold && !reset;
    push     = in_valid && in_ready;
    pop      = wr_en;
    wr_addr  = empty ? '0 : ent_q[rd_ptr_q].addr;
    wr_data  = empty ? '0 : ent_q[rd_ptr_q].data;
    count    = count_q;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    vld_d    = vld_q;
    if (pop)  vld_d[rd_ptr_q] = 1'b0;
    if (push) vld_d[wr_ptr_q] = 1'b1;
  end

  // Walk oldest to youngest so the last match wins; the incoming push is younger still.
  always_comb begin
    query_hit  = 1'b0;
    query_data = '0;
    idx        = '0;
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        idx = rd_ptr_q + PTR_W'(k);
        if (vld_q[idx] && ent_q[idx].addr == query_addr) begin
          query_hit  = 1'b1;
          query_data = ent_q[idx].data;
        end
      end
      if (push && in_addr == query_addr) begin
        query_hit  = 1'b1;
        query_data = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
    end
  end

  // Payload storage is not reset; valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (push) ent_q[wr_ptr_q] <= '{addr: in_addr, data: in_data};
  end
endmodule
